sub_bytes_seq: RTL and testbench



---
 rtl/sub_bytes_seq.sv | 196 +++++++++++++++++++
 tb/tb_sub_bytes_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: iterative AES-128 SubBytes stage feeding Shift_rows.
// Substitutes SBOX_LANES bytes per clock through shared S-box lanes, so a
// 128-bit block takes N = 16/SBOX_LANES cycles. Valid/ready on both sides.
// Optional macro SUBBYTES_INV_EN adds the `inv` port (inverse S-box select).

// One S-box lane: GF(2^8) inverse combined with the FIPS-197 affine map.
module sbox_lane (
`ifdef SUBBYTES_INV_EN
    input  logic       inv_i,
`endif
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

`ifdef SUBBYTES_INV_EN
    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction
`endif

    // Select forward or inverse substitution for this lane.
    always_comb begin
`ifdef SUBBYTES_INV_EN
        if (inv_i) begin
            byte_o = gf_inv(affine_inv(byte_i));
        end else begin
            byte_o = affine_fwd(gf_inv(byte_i));
        end
`else
        byte_o = affine_fwd(gf_inv(byte_i));
`endif
    end

endmodule

module sub_bytes_seq #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SUBBYTES_INV_EN
    input  logic         inv,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] sub
);

    localparam int N = 16 / SBOX_LANES;
    localparam logic [3:0] LAST_GRP = 4'(N - 1);

    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    // Element 15 is byte 0 ([127:120]), element 0 is byte 15 ([7:0]).
    logic [15:0][7:0] work_q, work_d;
    logic             inv_q, inv_d;

    logic [3:0]       grp_base;
    logic [7:0]       lane_in  [SBOX_LANES];
    logic [7:0]       lane_out [SBOX_LANES];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sub       = work_q;

    // First byte index of the group currently being substituted.
    always_comb begin
        grp_base = 4'(int'(cnt_q) * SBOX_LANES);
    end

    generate
        for (genvar gi = 0; gi < SBOX_LANES; gi++) begin : g_lane
            assign lane_in[gi] = work_q[4'd15 - grp_base - 4'(gi)];

            sbox_lane u_lane (
`ifdef SUBBYTES_INV_EN
                .inv_i  (inv_q),
`endif
                .byte_i (lane_in[gi]),
                .byte_o (lane_out[gi])
            );
        end
    endgenerate

`ifndef SUBBYTES_INV_EN
    // Forward-only build: direction flag is never used.
    logic unused_inv;
    assign unused_inv = inv_q;
`endif

    // Next-state: capture in IDLE, substitute one group per BUSY cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = state_in;
                    cnt_d   = 4'd0;
`ifdef SUBBYTES_INV_EN
                    inv_d   = inv;
`else
                    inv_d   = 1'b0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < SBOX_LANES; j++) begin
                    work_d[4'd15 - grp_base - 4'(j)] = lane_out[j];
                end
                if (cnt_q == LAST_GRP) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            work_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Testbench for sub_bytes_seq: directed vectors plus randomized blocks checked
// against a table-driven SubBytes model built from the FIPS-197 generator.
module tb_sub_bytes_seq;

    localparam int LANES = 4;
    localparam int NGRP  = 16 / LANES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] sub;
    logic         inv_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    sub_bytes_seq #(.SBOX_LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SUBBYTES_INV_EN
        .inv       (inv_s),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sub       (sub)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rol(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    // Walk the multiplicative group with generator 3 and its inverse to fill the table.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rol(q, 1) ^ rol(q, 2) ^ rol(q, 3) ^ rol(q, 4);
            fwd_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) begin
            inv_tab[fwd_tab[i]] = 8'(i);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = d[127 - 8 * k -: 8];
            r[127 - 8 * k -: 8] = iv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called right after a negedge; pushes one block through and checks every phase.
    task automatic run_block(input logic [127:0] d, input logic iv,
                             input logic [127:0] exp, input int stall);
        int lat;
        check_eq("idle_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        state_in = d;
        inv_s    = iv;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("busy_ready", 128'(in_ready), 128'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            state_in = rnd128();
            inv_s    = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 128'(lat), 128'(NGRP));
        check_eq("sub", sub, exp);
        check_eq("done_ready", 128'(in_ready), 128'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            state_in = rnd128();
            @(negedge clk);
            check_eq("stall_valid", 128'(out_valid), 128'd1);
            check_eq("stall_ready", 128'(in_ready), 128'd0);
            check_eq("stall_sub", sub, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_valid", 128'(out_valid), 128'd0);
        check_eq("post_ready", 128'(in_ready), 128'd1);
        check_eq("post_sub", sub, exp);
        $display("block in=%h inv=%0d out=%h lat=%0d stall=%0d", d, iv, sub, lat, stall);
    endtask

    initial begin
        logic [127:0] d;
        logic         iv;
        build_tables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        inv_s     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 128'(out_valid), 128'd0);
        check_eq("rst_ready", 128'(in_ready), 128'd1);
        check_eq("rst_sub", sub, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                  128'hd42711aee0bf98f1b8b45de51e415230, 0);
        run_block(128'h0, 1'b0, {16{8'h63}}, 1);
        run_block({16{8'hff}}, 1'b0, {16{8'h16}}, 5);

        // Reset during the second BUSY cycle discards the block.
        in_valid = 1'b1;
        state_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_valid", 128'(out_valid), 128'd0);
        check_eq("midrst_sub", sub, 128'h0);
        check_eq("midrst_ready", 128'(in_ready), 128'd1);
        $display("block reset mid-operation");
        run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                  128'hd42711aee0bf98f1b8b45de51e415230, 0);

        // Reset together with in_valid: nothing is captured.
        rst      = 1'b1;
        in_valid = 1'b1;
        state_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (NGRP + 2) @(negedge clk);
        check_eq("rstiv_valid", 128'(out_valid), 128'd0);
        check_eq("rstiv_sub", sub, 128'h0);
        $display("block reset with in_valid");

`ifdef SUBBYTES_INV_EN
        run_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                  128'h193de3bea0f4e22b9ac68d2ae9f84808, 0);
        run_block({16{8'h63}}, 1'b1, 128'h0, 2);
`endif

        for (int t = 0; t < 24; t++) begin
            d = rnd128();
`ifdef SUBBYTES_INV_EN
            iv = 1'($urandom_range(0, 1));
`else
            iv = 1'b0;
`endif
            run_block(d, iv, model(d, iv), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
